// File: rtl/irq_priority_ctrl.sv
// Interrupt priority controller: edge-detects sources, applies a mask, and
// presents one request at a time to the CPU with nested in-service tracking.
module irq_priority_ctrl #(
  parameter int unsigned N_SRC = 3,
  parameter int unsigned ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             irq_ack,
  input  logic             irq_eret,
  output logic             irq_req,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] in_service,
  output logic [N_SRC-1:0] mask
);

  typedef enum logic {IDLE, REQ} state_t;

  localparam logic [N_SRC-1:0] ONE = N_SRC'(1);

  state_t           state;
  logic [N_SRC-1:0] prev_in;
  logic [N_SRC-1:0] events;
  logic [N_SRC-1:0] open_bits;
  logic [N_SRC-1:0] id_onehot;
  logic [N_SRC-1:0] ack_set;
  logic [N_SRC-1:0] eret_clear;
  logic [N_SRC-1:0] pend_next;
  logic [N_SRC-1:0] ins_next;
  logic [ID_W-1:0]  cand;
  logic [ID_W-1:0]  ins_top;
  logic             cand_valid;
  logic             ins_valid;
  logic             eligible;
  logic             req_live;
  logic             ack_fire;

  // Previous input levels; loads during reset so a held level is not an event.
  always_ff @(posedge clk) begin
    prev_in <= irq_in;
  end

  // Priority encoding of the candidate and of the deepest in-service level.
  always_comb begin
    events     = irq_in & ~prev_in;
    open_bits  = pending & ~mask;
    cand_valid = 1'b0;
    cand       = '0;
    ins_valid  = 1'b0;
    ins_top    = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (open_bits[i]) begin
        cand_valid = 1'b1;
        cand       = ID_W'(i);
      end
      if (in_service[i]) begin
        ins_valid = 1'b1;
        ins_top   = ID_W'(i);
      end
    end
    eligible   = cand_valid && (!ins_valid || (cand > ins_top));
    id_onehot  = ONE << irq_id;
    req_live   = |(open_bits & id_onehot);
    ack_fire   = (state == REQ) && irq_ack;
    ack_set    = ack_fire ? id_onehot : '0;
    eret_clear = (irq_eret && ins_valid) ? (ONE << ins_top) : '0;
    pend_next  = (pending & ~ack_set) | events;
    ins_next   = (in_service & ~eret_clear) | ack_set;
  end

  // Request FSM plus pending, in-service and mask registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      irq_req    <= 1'b0;
      irq_id     <= '0;
      pending    <= '0;
      in_service <= '0;
      mask       <= '0;
    end else begin
      pending    <= pend_next;
      in_service <= ins_next;
      if (mask_we) begin
        mask <= mask_wdata;
      end
      case (state)
        IDLE: begin
          if (eligible) begin
            irq_id  <= cand;
            irq_req <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (irq_ack || !req_live) begin
            irq_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          irq_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/irq_priority_ctrl.md
Name: irq_priority_ctrl

Overview:
- Sequences external interrupt requests into the single-cycle RISC-V CPU.
- Edge-detects and latches up to N_SRC sources, applies a software mask, and picks the highest-priority eligible source.
- Presents one request to the CPU at a time with a req/ack handshake.
- Tracks nested in-service levels so only a higher-priority source can preempt; eret retires them.

Parameters:
N_SRC, 3, number of interrupt sources; index N_SRC-1 is highest priority
ID_W, 2, width of irq_id; must satisfy 2^ID_W >= N_SRC

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
irq_in  input  N_SRC  raw source levels, one bit per source, synchronous to clk
mask_we  input  1  write strobe for mask register
mask_wdata  input  N_SRC  new mask value; bit=1 disables source
irq_ack  input  1  CPU accepts current request (one-cycle pulse at trap entry)
irq_eret  input  1  CPU returns from interrupt handler (one-cycle pulse)
irq_req  output  1  interrupt request to CPU, registered
irq_id  output  ID_W  source index of current request, stable while irq_req=1
pending  output  N_SRC  latched, not yet acknowledged events
in_service  output  N_SRC  acknowledged, not yet retired sources
mask  output  N_SRC  current mask register

Behaviour:
- Reset is synchronous and active-high: rst=1 at a rising edge clears irq_req, irq_id, pending, in_service, mask and state (IDLE).
- During reset, prev_in still loads irq_in, so a level held high through reset is not an event.
- Edge detect: event[i] = irq_in[i] & ~prev_in[i]; prev_in <= irq_in every cycle.
- Pending set: pending[i] <= 1 on event[i].
- Pending clear: pending[i] <= 0 on ack of id i.
- Event and ack-clear on the same bit in the same cycle: pending stays 1, because the new event wins.
- Mask write: mask <= mask_wdata on mask_we. It takes effect in the following cycle's eligibility. Masking does not clear pending.
- Candidate: highest index i with pending[i] & ~mask[i].
- Eligible: candidate exists AND (in_service==0 OR candidate > highest set index of in_service).
- FSM IDLE: irq_req=0.
  - If eligible: irq_id <= candidate, irq_req <= 1, go to REQ.
  - irq_ack in IDLE is ignored.
- FSM REQ: irq_req=1; irq_id is held and not replaced by a newly arrived higher candidate.
  - On irq_ack: pending[irq_id] <= 0, in_service[irq_id] <= 1, irq_req <= 0, go to IDLE.
  - Without ack, if pending[irq_id]&~mask[irq_id] becomes 0 (masked): withdraw, irq_req <= 0, go to IDLE.
  - The ack check takes precedence over withdrawal in the same cycle.
- Eret: clears the highest set bit of in_service. Eret with in_service==0 is ignored.
- Eret and ack in the same cycle: apply the eret clear to the pre-ack in_service, then set the ack bit.
- Latency: a rising edge of irq_in first sampled at edge k shows pending=1 after edge k, and irq_req=1 after edge k+1 (if eligible and IDLE).
- After ack, irq_req is low for at least one cycle (IDLE) before any new request.
- No ID wrap concerns: ids not in 0..N_SRC-1 are never produced.

Test Plan:
- Reset/level: hold irq_in=3'b001 through rst, then release -> pending=0, irq_req stays 0. Then toggle irq_in[0] 0->1 -> pending=001 one cycle later, irq_req=1, irq_id=0 one cycle after that.
- Priority: events on sources 0 and 2 in the same cycle -> irq_id=2. Ack -> in_service=100, pending=001. Source 0 not requested while 2 is in service. Eret -> in_service=000, then irq_req=1, irq_id=0.
- Nesting: ack source 1 (in_service=010), then event on 2 -> irq_req=1, irq_id=2. Ack -> in_service=110. Eret -> 010. Eret -> 000.
- Mask/withdraw: source 1 pending, irq_req=1, irq_id=1. Write mask=010 with no ack -> irq_req=0 next cycle, pending still 010. Write mask=000 -> irq_req=1, irq_id=1 again.
- Simultaneous: ack of id 0 in the same cycle as a new event on source 0 -> pending[0] stays 1, in_service[0]=1. Eret+ack same cycle with in_service=010, irq_id=2 -> in_service=100.
- Spurious strobes: irq_ack in IDLE and irq_eret with in_service=0 -> no state change, all outputs unchanged.
